// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, word/jump widths, queue entry payload.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned JMP_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {instr, pc}; clear beats push and pop, head is registered.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CW-1:0]  count_n;
    logic           do_pop;
    fetch_entry_t   head_n;

    // Next pointers/count and the entry that will sit at the head after the edge
    always_comb begin
        rd_n    = rd_ptr;
        wr_n    = wr_ptr;
        count_n = count;
        head_n  = '0;
        do_pop  = pop && (count != '0);
        if (clear) begin
            rd_n    = '0;
            wr_n    = '0;
            count_n = '0;
        end else begin
            if (push)   wr_n = wr_ptr + PW'(1);
            if (do_pop) rd_n = rd_ptr + PW'(1);
            count_n = count + CW'(push) - CW'(do_pop);
            if (count_n != '0) begin
                // Queue momentarily empty: the new head is the entry being written now
                head_n = ((count - CW'(do_pop)) == '0) ? push_data : mem[rd_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= count_n;
            head       <= head_n;
            head_valid <= (count_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding word read, prefetch queue, redirect flush.
// Optional FETCH_STALL_CNT_EN adds a saturating decoder-starvation counter output.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              halt,
    input  logic              redirect,
    input  logic [JMP_W-1:0]  redirect_addr,
    output logic              mem_re,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_rdy,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [WORD_W-1:0] stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_n;
    logic [WORD_W-1:0] fetch_pc, pc_n, addr_n;
    logic [CW-1:0]     count;
    logic              push_c, pop_c, room_c, issue_c;
    fetch_entry_t      head;

    assign push_c  = (state == REQ) && mem_rdy && !redirect;
    assign pop_c   = instr_valid && instr_ready;
    assign room_c  = (count - CW'(pop_c) + CW'(push_c)) < CW'(DEPTH);
    assign issue_c = en && !halt && room_c && !redirect;

    always_comb begin
        state_n = state;
        pc_n    = fetch_pc;
        addr_n  = mem_addr;
        case (state)
            IDLE: begin
                if (issue_c) begin
                    state_n = REQ;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_n = mem_rdy ? IDLE : DISCARD;
                end else if (mem_rdy) begin
                    pc_n = fetch_pc + 32'd1;
                    if (issue_c) addr_n  = fetch_pc + 32'd1;
                    else         state_n = IDLE;
                end
            end
            DISCARD: begin
                if (mem_rdy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (redirect) pc_n = {{(WORD_W-JMP_W){1'b0}}, redirect_addr};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_re   <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= pc_n;
            mem_addr <= addr_n;
            mem_re   <= (state_n != IDLE);
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push_c),
        .pop        (pop_c),
        .clear      (redirect),
        .push_data  ('{instr: mem_data, pc: mem_addr}),
        .count      (count),
        .head_valid (instr_valid),
        .head       (head)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

`ifdef FETCH_STALL_CNT_EN
    // Cycles the decoder was ready but starved; survives redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (en && instr_ready && !instr_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: streaming, backpressure, redirect, PC wrap, halt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, halt = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    int          lat = 0;
    logic        mem_en = 1'b1;

    logic        mem_re_a, mem_rdy_a, instr_valid_a;
    logic [31:0] mem_addr_a, mem_data_a, instr_a, instr_pc_a;
    logic        mem_re_w, mem_rdy_w, instr_valid_w;
    logic [31:0] mem_addr_w, mem_data_w, instr_w, instr_pc_w;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_a, stall_cnt_w;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .en(en), .halt(halt), .redirect(redirect),
        .redirect_addr(redirect_addr), .mem_re(mem_re_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .mem_rdy(mem_rdy_a), .instr_valid(instr_valid_a),
        .instr(instr_a), .instr_pc(instr_pc_a), .instr_ready(instr_ready)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt_a)
`endif
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(rst), .en(en), .halt(halt), .redirect(redirect),
        .redirect_addr(redirect_addr), .mem_re(mem_re_w), .mem_addr(mem_addr_w),
        .mem_data(mem_data_w), .mem_rdy(mem_rdy_w), .instr_valid(instr_valid_w),
        .instr(instr_w), .instr_pc(instr_pc_w), .instr_ready(instr_ready)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt_w)
`endif
    );

    // Memory models: data = addr + A000, ready after 'lat' extra wait cycles
    int wcnt_a = 0;
    int wcnt_w = 0;
    assign mem_rdy_a  = mem_re_a && mem_en && (wcnt_a >= lat);
    assign mem_rdy_w  = mem_re_w && mem_en && (wcnt_w >= lat);
    assign mem_data_a = mem_addr_a + 32'hA000;
    assign mem_data_w = mem_addr_w + 32'hA000;
    always @(posedge clk) wcnt_a <= (!mem_re_a || mem_rdy_a) ? 0 : wcnt_a + 1;
    always @(posedge clk) wcnt_w <= (!mem_re_w || mem_rdy_w) ? 0 : wcnt_w + 1;

    typedef struct {
        logic        r, e, h, rdy, rd;
        logic [15:0] ra;
        int          l;
        logic        xre;
        logic [31:0] xaddr;
        logic        xv;
        logic [31:0] xi, xp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, e, h, rdy, rd, input logic [15:0] ra, input int l,
                       input logic xre, input logic [31:0] xaddr, input logic xv,
                       input logic [31:0] xi, xp);
        vec_t v;
        v.r = r; v.e = e; v.h = h; v.rdy = rdy; v.rd = rd; v.ra = ra; v.l = l;
        v.xre = xre; v.xaddr = xaddr; v.xv = xv; v.xi = xi; v.xp = xp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //  rst en hlt rdy rdr raddr   lat  re addr        v  instr       pc
        // stream, zero-wait, decoder always ready
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h1,       1, 32'hA000,   32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h2,       1, 32'hA001,   32'h1);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h3,       1, 32'hA002,   32'h2);
        // decoder stalls: queue fills to 4, fetch stops
        add(1, 1, 0, 0, 0, 16'h0,  0,  1, 32'h4,       1, 32'hA002,   32'h2);
        add(1, 1, 0, 0, 0, 16'h0,  0,  1, 32'h5,       1, 32'hA002,   32'h2);
        add(1, 1, 0, 0, 0, 16'h0,  0,  0, 32'h5,       1, 32'hA002,   32'h2);
        add(1, 1, 0, 0, 0, 16'h0,  0,  0, 32'h5,       1, 32'hA002,   32'h2);
        // decoder resumes: drain in order, fetch resumes at 6
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h6,       1, 32'hA003,   32'h3);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h7,       1, 32'hA004,   32'h4);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h8,       1, 32'hA005,   32'h5);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h9,       1, 32'hA006,   32'h6);
        // reset mid-request, then 3-cycle memory with redirect in 2nd wait cycle
        add(0, 1, 0, 1, 0, 16'h0,  2,  0, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 1, 16'h40, 2,  1, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  0, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h40,      0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h40,      0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h40,      0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h41,      1, 32'hA040,   32'h40);
        add(1, 1, 0, 1, 0, 16'h0,  2,  1, 32'h41,      0, 32'h0,      32'h0);
        // redirect coincident with pop and mem_rdy in REQ
        add(0, 1, 0, 1, 0, 16'h0,  0,  0, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h0,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h1,       1, 32'hA000,   32'h0);
        add(1, 1, 0, 1, 1, 16'h10, 0,  0, 32'h1,       0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h10,      0, 32'h0,      32'h0);
        add(1, 1, 0, 1, 0, 16'h0,  0,  1, 32'h11,      1, 32'hA010,   32'h10);

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_re", 32'(mem_re_a), 32'h0);
        chk("rst mem_addr", mem_addr_a, 32'h0);
        chk("rst valid", 32'(instr_valid_a), 32'h0);
        chk("rst instr", instr_a, 32'h0);
        chk("rst instr_pc", instr_pc_a, 32'h0);
        chk("rst mem_addr_w", mem_addr_w, 32'hFFFF_FFFF);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; en = tbl[i].e; halt = tbl[i].h; instr_ready = tbl[i].rdy;
            redirect = tbl[i].rd; redirect_addr = tbl[i].ra; lat = tbl[i].l;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_re", i), 32'(mem_re_a), 32'(tbl[i].xre));
            if (tbl[i].xre || !tbl[i].r)
                chk($sformatf("v%0d mem_addr", i), mem_addr_a, tbl[i].xaddr);
            chk($sformatf("v%0d valid", i), 32'(instr_valid_a), 32'(tbl[i].xv));
            chk($sformatf("v%0d instr", i), instr_a, tbl[i].xi);
            chk($sformatf("v%0d instr_pc", i), instr_pc_a, tbl[i].xp);
        end

        // PC wrap from RESET_PC=FFFFFFFF, then halt during REQ
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; halt = 1'b0; en = 1'b1; instr_ready = 1'b1; lat = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("wrap e1 mem_re", 32'(mem_re_w), 32'h1);
        chk("wrap e1 mem_addr", mem_addr_w, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap e2 pc", instr_pc_w, 32'hFFFF_FFFF);
        chk("wrap e2 instr", instr_w, 32'h0000_9FFF);
        chk("wrap e2 mem_addr", mem_addr_w, 32'h0);
        @(posedge clk); #1;
        chk("wrap e3 pc", instr_pc_w, 32'h0);
        chk("wrap e3 instr", instr_w, 32'hA000);
        @(posedge clk); #1;
        chk("wrap e4 pc", instr_pc_w, 32'h1);
        chk("wrap e4 mem_addr", mem_addr_w, 32'h2);
        @(negedge clk);
        halt = 1'b1;
        @(posedge clk); #1;
        chk("halt e5 mem_re", 32'(mem_re_w), 32'h0);
        chk("halt e5 valid", 32'(instr_valid_w), 32'h1);
        chk("halt e5 pc", instr_pc_w, 32'h2);
        chk("halt e5 instr", instr_w, 32'hA002);
        @(posedge clk); #1;
        chk("halt e6 mem_re", 32'(mem_re_w), 32'h0);
        chk("halt e6 valid", 32'(instr_valid_w), 32'h0);

`ifdef FETCH_STALL_CNT_EN
        // Memory never ready: five starved cycles after reset release
        @(negedge clk);
        rst = 1'b0; halt = 1'b0; en = 1'b1; instr_ready = 1'b1; mem_en = 1'b0;
        @(negedge clk);
        chk("stall rst", stall_cnt_a, 32'h0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_cnt", stall_cnt_a, 32'd5);
        mem_en = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
